// File: rtl/xalu_word_seq.sv
// xalu_word_seq: nibble-serial word sequencer that drives one external 4-bit
// combinational ALU slice.
// A word operation is latched on start. It is then issued to the slice one
// nibble per clock for NIBBLES cycles, with the carry chained between nibbles.
// The word result and flags appear together for a single-cycle DONE state.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             request, sampled in IDLE/DONE only
//   func, com         slice function code and 1's-complement output mode
//   a, b, cin         word operands and word carry/shift-in
//   busy, done        RUN indicator and one-cycle completion pulse
//   result, cout      assembled word result and word carry/shift-out
//   zero, equ         result == 0; a == b over all nibbles
//   sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left   to the slice
//   sl_d, sl_co_left, sl_co_right, sl_equ               from the slice
module xalu_word_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             func,
  input  logic                   com,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   zero,
  output logic                   equ,
  output logic [3:0]             sl_a,
  output logic [3:0]             sl_b,
  output logic [2:0]             sl_f,
  output logic                   sl_com,
  output logic                   sl_ci_right,
  output logic                   sl_ci_left,
  input  logic [3:0]             sl_d,
  input  logic                   sl_co_left,
  input  logic                   sl_co_right,
  input  logic                   sl_equ
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_SHL = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_func;
  logic          r_com;
  logic          r_cin;
  logic          r_carry;
  logic [W-1:0]  r_acc;
  logic          r_equ_acc;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_zero;
  logic          r_equ;

  logic          w_run;
  logic          w_shr;
  logic          w_first;
  logic          w_last;
  logic [CW-1:0] w_idx;
  logic          w_chain_in;
  logic [W-1:0]  w_acc_next;
  logic          w_equ_next;
  logic          w_cout_last;

  always_comb begin
    w_run      = (r_state == S_RUN);
    w_shr      = (r_func == F_SHR);
    w_first    = (r_cnt == '0);
    w_last     = (r_cnt == LAST);
    // SHR walks from the MSB nibble down; everything else walks up from the LSB
    w_idx      = w_shr ? (LAST - r_cnt) : r_cnt;
    w_chain_in = w_first ? r_cin : r_carry;

    sl_a        = '0;
    sl_b        = '0;
    sl_f        = '0;
    sl_com      = 1'b0;
    sl_ci_right = 1'b0;
    sl_ci_left  = 1'b0;
    if (w_run) begin
      sl_a        = r_a[{w_idx, 2'b00} +: 4];
      sl_b        = r_b[{w_idx, 2'b00} +: 4];
      sl_f        = r_func;
      sl_com      = r_com;
      sl_ci_right = w_shr ? 1'b0 : w_chain_in;
      sl_ci_left  = w_shr ? w_chain_in : 1'b0;
    end

    // Merge the nibble the slice is producing this cycle, so the final
    // nibble is included when the word result is committed at the last edge.
    w_acc_next = r_acc;
    w_acc_next[{w_idx, 2'b00} +: 4] = sl_d;
    w_equ_next = sl_equ & (w_first | r_equ_acc);

    case (r_func)
      F_ADD, F_SHL: w_cout_last = sl_co_left;
      F_SHR:        w_cout_last = sl_co_right;
      default:      w_cout_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_func    <= '0;
      r_com     <= 1'b0;
      r_cin     <= 1'b0;
      r_carry   <= 1'b0;
      r_acc     <= '0;
      r_equ_acc <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_zero    <= 1'b0;
      r_equ     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_a       <= a;
            r_b       <= b;
            r_func    <= func;
            r_com     <= com;
            r_cin     <= cin;
            r_carry   <= 1'b0;
            r_acc     <= '0;
            r_equ_acc <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc     <= w_acc_next;
          r_equ_acc <= w_equ_next;
          r_carry   <= w_shr ? sl_co_right : sl_co_left;
          if (w_last) begin
            r_state  <= S_DONE;
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_equ    <= w_equ_next;
            r_cout   <= w_cout_last;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;
  assign equ    = r_equ;

endmodule

// File: tb/tb_xalu_word_seq.sv
// Bench for xalu_word_seq (NIBBLES=4) with a behavioural 4-bit slice attached
// to the sl_* pins and a word-level reference model feeding a scoreboard.
module tb_xalu_word_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func;
  logic        com;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        equ;
  logic [3:0]  sl_a;
  logic [3:0]  sl_b;
  logic [2:0]  sl_f;
  logic        sl_com;
  logic        sl_ci_right;
  logic        sl_ci_left;
  logic [3:0]  sl_d;
  logic        sl_co_left;
  logic        sl_co_right;
  logic        sl_equ;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        eq;
  } exp_t;

  exp_t sb[$];

  logic [3:0] tr_a  [4];
  logic       tr_cr [4];
  logic       tr_cl [4];

  always #5 clk = ~clk;

  xalu_word_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .com(com),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .equ(equ), .sl_a(sl_a), .sl_b(sl_b),
    .sl_f(sl_f), .sl_com(sl_com), .sl_ci_right(sl_ci_right),
    .sl_ci_left(sl_ci_left), .sl_d(sl_d), .sl_co_left(sl_co_left),
    .sl_co_right(sl_co_right), .sl_equ(sl_equ)
  );

  // Behavioural 4-bit combinational slice (responder)
  logic [4:0] t_sum;
  always_comb begin
    t_sum       = '0;
    sl_d        = '0;
    sl_co_left  = 1'b0;
    sl_co_right = 1'b0;
    case (sl_f)
      3'd0: begin
        t_sum      = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, sl_ci_right};
        sl_d       = t_sum[3:0];
        sl_co_left = t_sum[4];
      end
      3'd1: sl_d = sl_a & sl_b;
      3'd2: sl_d = sl_a | sl_b;
      3'd3: sl_d = sl_a ^ sl_b;
      3'd4: sl_d = sl_a;
      3'd5: sl_d = sl_b;
      3'd6: begin
        sl_d        = {sl_ci_left, sl_a[3:1]};
        sl_co_right = sl_a[0];
      end
      default: begin
        sl_d       = {sl_a[2:0], sl_ci_right};
        sl_co_left = sl_a[3];
      end
    endcase
    if (sl_com) sl_d = ~sl_d;
    sl_equ = (sl_a == sl_b);
  end

  function automatic exp_t model(input logic [2:0] f, input logic c,
                                 input logic [15:0] x, input logic [15:0] y,
                                 input logic ci);
    exp_t        e;
    logic [16:0] s;
    e = '0;
    s = '0;
    case (f)
      3'd0: begin
        s     = {1'b0, x} + {1'b0, y} + {16'b0, ci};
        e.res = s[15:0];
        e.co  = s[16];
      end
      3'd1: e.res = x & y;
      3'd2: e.res = x | y;
      3'd3: e.res = x ^ y;
      3'd4: e.res = x;
      3'd5: e.res = y;
      3'd6: begin e.res = {ci, x[15:1]}; e.co = x[0];  end
      default: begin e.res = {x[14:0], ci}; e.co = x[15]; end
    endcase
    if (c) e.res = ~e.res;
    e.z  = (e.res == 16'h0000);
    e.eq = (x == y);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout",   32'(cout),   32'(e.co));
        chk("zero",   32'(zero),   32'(e.z));
        chk("equ",    32'(equ),    32'(e.eq));
      end
    end
  end

  // Issue one op; returns on the negedge of its DONE cycle. With b2b the
  // start is driven immediately (caller is sitting in a DONE cycle).
  task automatic run_op(input logic [2:0] f, input logic c, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci, input bit b2b,
                        input int poke_at);
    int lat;
    if (!b2b) @(negedge clk);
    func  = f; com = c; a = av; b = bv; cin = ci;
    start = 1'b1;
    sb.push_back(model(f, c, av, bv, ci));
    @(negedge clk);
    start = 1'b0;
    a    = 16'($urandom);
    b    = 16'($urandom);
    func = 3'($urandom);
    com  = 1'($urandom);
    cin  = 1'($urandom);
    lat  = 1;
    chk("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tr_a[i]  = sl_a;
      tr_cr[i] = sl_ci_right;
      tr_cl[i] = sl_ci_left;
      start    = (i == poke_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; func = '0; com = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({result, cout, zero, equ}), 32'd0);
    chk("rst_sl", 32'({sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}), 32'd0);
    start = 1'b1; func = 3'd0; a = 16'h1111;
    @(negedge clk);
    chk("rst_beats_start", 32'(busy), 32'd0);
    start = 1'b0; rst = 1'b0;

    run_op(3'd0, 1'b0, 16'h1234, 16'h0FCC, 1'b0, 1'b0, -1);

    run_op(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("add_ci_right%0d", i), 32'(tr_cr[i]), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("add_ci_left%0d", i), 32'(tr_cl[i]), 32'd0);
    end

    run_op(3'd7, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b0, -1);

    run_op(3'd6, 1'b0, 16'h8001, 16'h0000, 1'b1, 1'b0, -1);
    chk("shr_sl_a", 32'({tr_a[0], tr_a[1], tr_a[2], tr_a[3]}), 32'h8001);
    chk("shr_ci_left", 32'({tr_cl[0], tr_cl[1], tr_cl[2], tr_cl[3]}), 32'b1000);
    chk("shr_ci_right", 32'({tr_cr[0], tr_cr[1], tr_cr[2], tr_cr[3]}), 32'd0);

    run_op(3'd3, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, -1);
    run_op(3'd4, 1'b1, 16'h00FF, 16'h1234, 1'b0, 1'b0, -1);

    // start pulsed mid-RUN must be dropped, not queued
    run_op(3'd0, 1'b0, 16'h0101, 16'h0202, 1'b1, 1'b0, 1);
    @(negedge clk);
    chk("poke_not_queued", 32'({busy, done}), 32'd0);

    // back-to-back: second start lands in the DONE cycle of the first
    run_op(3'd2, 1'b0, 16'hF000, 16'h000F, 1'b0, 1'b0, -1);
    run_op(3'd5, 1'b0, 16'hAAAA, 16'h4321, 1'b0, 1'b1, -1);

    // reset during the second RUN cycle aborts with no done pulse
    @(negedge clk);
    func = 3'd0; com = 1'b0; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    run_op(3'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, -1);

    for (int n = 0; n < 6; n++) begin
      run_op(3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom), 1'b0, -1);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
